// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//   Avalon-MM slave that queues HD44780 instruction/data bytes in a small FIFO
//   and paces them onto the character LCD bus with setup, enable pulse, hold
//   and execution-wait timing.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   address[1:0]            0: push instruction, 1: push data,
//                           2: status read, 3: control write
//   chipselect, write_n     write strobe = chipselect & ~write_n
//   writedata[31:0]         byte in [7:0]; control bits [1:0] at address 3
//   readdata[31:0]          combinational status ({count, overflow, busy}) at address 2
//   lcd_data[7:0], lcd_rs   latched byte and register select of the last transfer
//   lcd_rw                  constant 0 (panel is write-only)
//   lcd_en                  enable strobe
module lcd_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int T_SETUP     = 4,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en
);

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TS   = at_least_one(T_SETUP);
  localparam int TP   = at_least_one(T_PULSE);
  localparam int TH   = at_least_one(T_HOLD);
  localparam int TE   = at_least_one(T_EXEC);
  localparam int TL   = at_least_one(T_EXEC_LONG);
  localparam int TMAX = max2(max2(max2(TS, TP), max2(TH, TE)), TL);
  localparam int CW   = $clog2(TMAX) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(TS);
  localparam logic [CW-1:0] LD_PULSE = CW'(TP);
  localparam logic [CW-1:0] LD_HOLD  = CW'(TH);
  localparam logic [CW-1:0] LD_EXEC  = CW'(TE);
  localparam logic [CW-1:0] LD_LONG  = CW'(TL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic wr, push_req, flush, clr_ovf, full, empty, pop, push_ok, long_exec, busy;
  logic unused_wdata;

  assign wr       = chipselect & ~write_n;
  assign push_req = wr & ~address[1];
  assign flush    = wr & (address == 2'd3) & writedata[1];
  assign clr_ovf  = wr & (address == 2'd3) & writedata[0];
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok  = push_req & ~flush & (~full | pop);
  assign busy     = (state != IDLE) | ~empty;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_exec = ~lcd_rs & ((lcd_data == 8'h01) | (lcd_data == 8'h02) | (lcd_data == 8'h03));

  assign readdata     = (address == 2'd2) ? {25'b0, 5'(count), overflow, busy} : 32'b0;
  assign lcd_rw       = 1'b0;
  // Decoded straight from the state register so an asynchronous reset drops EN at once.
  assign lcd_en       = (state == PULSE);
  assign unused_wdata = ^writedata[31:8];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {address[0], writedata[7:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (clr_ovf)
        overflow <= 1'b0;
      else if (push_req & ~flush & full & ~pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop) begin
        lcd_data <= mem[rd_ptr][7:0];
        lcd_rs   <= mem[rd_ptr][8];
      end
    end
  end

  // Each timed state is entered with its length loaded and leaves when the
  // counter reaches 1, so a state lasts exactly its load value in cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_ONE) begin
          state_nxt = PULSE;
          cnt_nxt   = LD_PULSE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == CNT_ONE) begin
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == CNT_ONE) begin
          state_nxt = WAIT;
          cnt_nxt   = long_exec ? LD_LONG : LD_EXEC;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CNT_ONE) state_nxt = IDLE;
        else                cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
//   Self-checking bench for lcd_sequencer. A transaction-level reference model
//   (a queue plus the cycle numbers of the current transfer) predicts every
//   output each cycle; table-driven register vectors, hand-written timing
//   sequences and a randomized phase drive the DUT.
module tb_lcd_sequencer;

  localparam int DEPTH = 8;
  localparam int TS    = 4;
  localparam int TP    = 12;
  localparam int TH    = 4;
  localparam int TE    = 40;
  localparam int TL    = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en;

  lcd_sequencer #(
    .FIFO_DEPTH(DEPTH), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .T_EXEC(TE), .T_EXEC_LONG(TL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  int         c;
  int         pop_cyc;
  int         end_cyc;
  logic [7:0] d_m;
  logic       rs_m;
  logic       ovf_m;
  logic [8:0] m_q[$];

  // values sampled in the last cycle
  int          s_cyc;
  logic        s_en, s_rs;
  logic [7:0]  s_data;
  logic [31:0] s_rd;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, c);
    end
  endfunction

  function automatic void model_reset();
    c       = 0;
    pop_cyc = -1;
    end_cyc = 0;
    d_m     = 8'h00;
    rs_m    = 1'b0;
    ovf_m   = 1'b0;
    m_q.delete();
  endfunction

  // One bus cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input logic cs_i, input logic wn_i, input logic [1:0] a_i, input logic [31:0] wd_i);
    logic        idle, en_e, busy_e, full, pop, wr;
    logic [31:0] st;
    logic [8:0]  head;
    chipselect = cs_i;
    write_n    = wn_i;
    address    = a_i;
    writedata  = wd_i;
    @(negedge clk);
    idle   = (c >= end_cyc);
    en_e   = (pop_cyc >= 0) && (c >= pop_cyc + 1 + TS) && (c <= pop_cyc + TS + TP);
    busy_e = !idle || (m_q.size() != 0);
    st     = {25'b0, 5'(m_q.size()), ovf_m, busy_e};
    s_cyc = c; s_en = lcd_en; s_rs = lcd_rs; s_data = lcd_data; s_rd = readdata;
    chk("lcd_en", lcd_en, en_e);
    chk("lcd_data", lcd_data, d_m);
    chk("lcd_rs", lcd_rs, rs_m);
    chk("lcd_rw", lcd_rw, 0);
    chk("readdata", readdata, (a_i == 2'd2) ? st : 32'h0);
    wr   = cs_i && !wn_i;
    full = (m_q.size() == DEPTH);
    pop  = idle && (m_q.size() != 0);
    if (pop) begin
      head    = m_q.pop_front();
      pop_cyc = c;
      d_m     = head[7:0];
      rs_m    = head[8];
      end_cyc = c + 1 + TS + TP + TH +
                ((!head[8] && (head[7:0] inside {8'h01, 8'h02, 8'h03})) ? TL : TE);
    end
    if (wr && a_i == 2'd3) begin
      if (wd_i[1]) m_q.delete();
      if (wd_i[0]) ovf_m = 1'b0;
    end else if (wr && !a_i[1]) begin
      if (!full || pop) m_q.push_back({a_i[0], wd_i[7:0]});
      else              ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  initial begin
    int   g, dv, rise, rise1, rise2, en_cnt, busy_cnt, nrise;
    logic prev_en, tmo;
    int   r;

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd2; writedata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_lcd_en", lcd_en, 0);
    chk("reset_lcd_data", lcd_data, 0);
    chk("reset_lcd_rs", lcd_rs, 0);
    chk("reset_status", readdata, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // register-map vectors: fill FIFO while first byte is in flight, overflow, clear
    vt.push_back('{1'b1, 1'b1, 2'd2, 32'h0, 32'h0});
    for (int i = 0; i < 10; i++) vt.push_back('{1'b1, 1'b0, 2'd1, 32'h30 + i, 32'h0});
    vt.push_back('{1'b1, 1'b1, 2'd2, 32'h0, 32'h23});
    vt.push_back('{1'b1, 1'b0, 2'd3, 32'h1, 32'h0});
    vt.push_back('{1'b1, 1'b1, 2'd2, 32'h0, 32'h21});
    vt.push_back('{1'b1, 1'b1, 2'd0, 32'h0, 32'h0});
    vt.push_back('{1'b1, 1'b1, 2'd1, 32'h0, 32'h0});
    vt.push_back('{1'b1, 1'b1, 2'd3, 32'h0, 32'h0});
    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].cs, vt[i].wn, vt[i].addr, vt[i].wd);
      chk($sformatf("table_rd[%0d]", i), s_rd, vt[i].exp_rd);
    end

    // full FIFO: push in the very cycle the head is popped
    for (g = 0; g < 500 && c < end_cyc; g++) cycle(1'b0, 1'b1, 2'd0, 32'h0);
    tmo = (c < end_cyc);
    chk("full_wait_timeout", tmo, 0);
    cycle(1'b1, 1'b0, 2'd1, 32'h55);
    cycle(1'b1, 1'b1, 2'd2, 32'h0);
    chk("push_pop_full_status", s_rd, 32'h21);

    // flush during WAIT: current wait completes, nothing else goes out
    for (g = 0; g < 500 && c < pop_cyc + 1 + TS + TP + TH; g++) cycle(1'b0, 1'b1, 2'd0, 32'h0);
    tmo = (c < pop_cyc + 1 + TS + TP + TH);
    chk("wait_phase_timeout", tmo, 0);
    cycle(1'b1, 1'b0, 2'd3, 32'h2);
    cycle(1'b1, 1'b1, 2'd2, 32'h0);
    chk("flush_status", s_rd, 32'h1);
    nrise = 0;
    for (g = 0; g < 200 && s_rd[0]; g++) begin
      cycle(1'b1, 1'b1, 2'd2, 32'h0);
      if (s_en) nrise++;
    end
    chk("flush_busy_timeout", s_rd[0], 0);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b1, 2'd2, 32'h0);
      if (s_en) nrise++;
    end
    chk("flush_no_en", nrise, 0);
    chk("flush_idle_status", s_rd, 0);

    // single data byte 0x41: latency, EN width, busy length
    cycle(1'b1, 1'b0, 2'd1, 32'h41);
    dv = -1; rise = -1; en_cnt = 0; busy_cnt = 0;
    for (g = 0; g < 200; g++) begin
      cycle(1'b1, 1'b1, 2'd2, 32'h0);
      if (dv < 0 && s_data == 8'h41 && s_rs) dv = s_cyc;
      if (s_en) begin
        en_cnt++;
        if (rise < 0) rise = s_cyc;
      end
      if (s_rd[0]) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    chk("t1_data_latency", dv - (c - busy_cnt - 2), 2);
    chk("t1_en_after_dv", rise - dv, TS);
    chk("t1_en_width", en_cnt, TP);
    chk("t1_busy_cycles", busy_cnt, 1 + TS + TP + TH + TE);

    // clear display then function set: long execution wait between EN rises
    cycle(1'b1, 1'b0, 2'd0, 32'h01);
    cycle(1'b1, 1'b0, 2'd0, 32'h38);
    dv = -1; rise1 = -1; rise2 = -1; prev_en = 1'b0; busy_cnt = 0;
    for (g = 0; g < 1000; g++) begin
      cycle(1'b1, 1'b1, 2'd2, 32'h0);
      if (dv < 0 && s_data == 8'h01) dv = s_cyc;
      if (s_en && !prev_en) begin
        if (rise1 < 0) rise1 = s_cyc;
        else if (rise2 < 0) rise2 = s_cyc;
      end
      prev_en = s_en;
      if (s_rd[0]) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    chk("t2_rise_to_rise", rise2 - rise1, 1 + TS + TP + TH + TL);
    chk("t2_dv_to_rise2", rise2 - dv, TL + TS + TP + TH + 1 + TS);
    chk("t2_busy_timeout", s_rd[0], 0);

    // reset during PULSE
    cycle(1'b1, 1'b0, 2'd1, 32'h77);
    for (g = 0; g < 50 && !s_en; g++) cycle(1'b0, 1'b1, 2'd0, 32'h0);
    chk("t5_en_seen", s_en, 1);
    chipselect = 1'b0;
    address    = 2'd2;
    reset_n    = 1'b0;
    #1;
    chk("t5_en_async_reset", lcd_en, 0);
    chk("t5_data_async_reset", lcd_data, 0);
    chk("t5_rs_async_reset", lcd_rs, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cycle(1'b1, 1'b1, 2'd2, 32'h0);
    chk("t5_status_after_reset", s_rd, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)
        cycle(1'b1, 1'b0, 2'($urandom_range(0, 1)), $urandom);
      else if (r < 40)
        cycle(1'b1, 1'b1, 2'd2, $urandom);
      else if (r < 43)
        cycle(1'b1, 1'b0, 2'd3, 32'($urandom_range(0, 3)));
      else if (r < 46)
        cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      else
        cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
